// File: rtl/case_eq_pkg.sv
// Shared types and default constants for the case-block equivalence sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package case_eq_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default geometry of the compared case block and its signature register
   localparam int N_IN_DEF  = 10;
   localparam int N_OUT_DEF = 5;
   localparam int SIG_W_DEF = 16;

   // CRC-16-CCITT style feedback, seeded at zero
   localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
   localparam logic [15:0] MISR_SEED_DEF = 16'h0000;

endpackage

// File: rtl/case_eq_misr.sv
// Multiple-input signature register compressing the reference outputs of a sweep.
// Latency: one cycle from an enabled sample to the updated signature; next value also offered combinationally.
// Backpressure: none; samples whenever en is high, load has priority over en.
module case_eq_misr
   import case_eq_pkg::*;
#(
   parameter int                N_OUT = N_OUT_DEF,
   parameter int                SIG_W = SIG_W_DEF,
   parameter logic [SIG_W-1:0]  POLY  = MISR_POLY_DEF,
   parameter logic [SIG_W-1:0]  SEED  = MISR_SEED_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               en,
   input  logic [N_OUT-1:0]   din,
   output logic [SIG_W-1:0]   sig,
   output logic [SIG_W-1:0]   sig_nxt
);

   logic [SIG_W-1:0] shifted;

   // Shift left, fold the dropped MSB back through the polynomial, then mix in the sample
   always_comb begin
      shifted = {sig[SIG_W-2:0], 1'b0};
      sig_nxt = shifted ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
   end

   // Signature register: seed on reset or load, advance on enabled samples
   always_ff @(posedge clk) begin
      if (rst || load) begin
         sig <= SEED;
      end else if (en) begin
         sig <= sig_nxt;
      end
   end

endmodule

// File: rtl/case_eq_sequencer.sv
// Exhaustive input sweep comparing a reference and an optimised case-block netlist, with MISR of the reference.
// Latency: SETTLE_CYC+1 cycles per vector; done rises the cycle after the last vector is sampled.
// Backpressure: none; start ignored while sweeping, abort ends a sweep and returns to IDLE.
module case_eq_sequencer
   import case_eq_pkg::*;
#(
   parameter int                N_IN       = N_IN_DEF,
   parameter int                N_OUT      = N_OUT_DEF,
   parameter int                SETTLE_CYC = 0,
   parameter int                SIG_W      = SIG_W_DEF,
   parameter logic [SIG_W-1:0]  MISR_POLY  = MISR_POLY_DEF,
   parameter logic [SIG_W-1:0]  MISR_SEED  = MISR_SEED_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [N_IN-1:0]    vec_o,
   input  logic [N_OUT-1:0]   ref_y_i,
   input  logic [N_OUT-1:0]   dut_y_i,
   input  logic [SIG_W-1:0]   golden_sig_i,
   input  logic               sig_chk_en_i,
   output logic               busy,
   output logic               done,
   output logic [N_IN:0]      mismatch_cnt,
   output logic [N_IN-1:0]    first_fail_vec,
   output logic               first_fail_valid,
   output logic [SIG_W-1:0]   signature,
   output logic               pass
);

   localparam logic [3:0]      SETTLE_L = 4'(SETTLE_CYC);
   localparam logic [N_IN-1:0] VEC_LAST = '1;
   localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);

   state_t            state, state_nxt;
   logic [3:0]        wcnt, wcnt_nxt;
   logic [N_IN-1:0]   vec_nxt;
   logic [N_IN:0]     cnt_nxt;
   logic [N_IN-1:0]   ffvec_nxt;
   logic              ffv_nxt;
   logic              pass_nxt;
   logic              misr_load;
   logic              misr_en;
   logic              miscompare;
   logic [SIG_W-1:0]  sig_nxt;

   case_eq_misr #(
      .N_OUT (N_OUT),
      .SIG_W (SIG_W),
      .POLY  (MISR_POLY),
      .SEED  (MISR_SEED)
   ) u_misr (
      .clk     (clk),
      .rst     (rst),
      .load    (misr_load),
      .en      (misr_en),
      .din     (ref_y_i),
      .sig     (signature),
      .sig_nxt (sig_nxt)
   );

   assign busy       = (state == WAIT);
   assign done       = (state == DONE);
   assign miscompare = (ref_y_i != dut_y_i);

   // Next-state and next-result computation; sampling happens when the settle count reaches zero
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      vec_nxt   = vec_o;
      cnt_nxt   = mismatch_cnt;
      ffvec_nxt = first_fail_vec;
      ffv_nxt   = first_fail_valid;
      pass_nxt  = 1'b0;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = WAIT;
               vec_nxt   = '0;
               wcnt_nxt  = SETTLE_L;
               cnt_nxt   = '0;
               ffvec_nxt = '0;
               ffv_nxt   = 1'b0;
               misr_load = 1'b1;
            end else if (state == DONE) begin
               // Re-evaluated every cycle so golden/enable changes are reflected
               pass_nxt = (mismatch_cnt == '0) &&
                          (!sig_chk_en_i || (signature == golden_sig_i));
            end
         end
         WAIT: begin
            if (abort) begin
               state_nxt = IDLE;
               vec_nxt   = '0;
               wcnt_nxt  = '0;
            end else if (wcnt != 4'd0) begin
               wcnt_nxt = wcnt - 4'd1;
            end else begin
               misr_en = 1'b1;
               if (miscompare) begin
                  cnt_nxt = mismatch_cnt + CNT_ONE;
                  if (!first_fail_valid) begin
                     ffvec_nxt = vec_o;
                     ffv_nxt   = 1'b1;
                  end
               end
               if (vec_o == VEC_LAST) begin
                  // Vector holds at all-ones; pass uses this cycle's final results
                  state_nxt = DONE;
                  pass_nxt  = (cnt_nxt == '0) &&
                              (!sig_chk_en_i || (sig_nxt == golden_sig_i));
               end else begin
                  vec_nxt  = vec_o + VEC_ONE;
                  wcnt_nxt = SETTLE_L;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         wcnt             <= '0;
         vec_o            <= '0;
         mismatch_cnt     <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         pass             <= 1'b0;
      end else begin
         state            <= state_nxt;
         wcnt             <= wcnt_nxt;
         vec_o            <= vec_nxt;
         mismatch_cnt     <= cnt_nxt;
         first_fail_vec   <= ffvec_nxt;
         first_fail_valid <= ffv_nxt;
         pass             <= pass_nxt;
      end
   end

endmodule

// File: tb/tb_case_eq_sequencer.sv
// Directed bench for the case-block sweep sequencer (settle 0 and settle 2 instances).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_case_eq_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Stand-in for the original netlist
   function automatic logic [4:0] ref_fn(input logic [9:0] v);
      return v[4:0] ^ v[9:5] ^ {4'b0000, ^v[9:7]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [4:0] r);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'd0, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- settle-0 instance ----------------
   logic        start0 = 1'b0, abort0 = 1'b0;
   logic [9:0]  vec0;
   logic [4:0]  ref0, dut0;
   logic [15:0] golden0 = 16'h0000;
   logic        en0 = 1'b0;
   logic        busy0, done0, ffv0, pass0;
   logic [10:0] cnt0;
   logic [9:0]  ffvec0;
   logic [15:0] sig0;
   logic        inj = 1'b0, zero_mode = 1'b0;

   assign ref0 = zero_mode ? 5'd0 : ref_fn(vec0);
   assign dut0 = ref0 ^ ((inj && vec0 == 10'h2A5) ? 5'h01 : 5'h00);

   case_eq_sequencer #(.SETTLE_CYC(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .vec_o(vec0),
      .ref_y_i(ref0), .dut_y_i(dut0), .golden_sig_i(golden0), .sig_chk_en_i(en0),
      .busy(busy0), .done(done0), .mismatch_cnt(cnt0), .first_fail_vec(ffvec0),
      .first_fail_valid(ffv0), .signature(sig0), .pass(pass0)
   );

   // ---------------- settle-2 instance ----------------
   logic        start2 = 1'b0;
   logic [9:0]  vec2;
   logic [4:0]  ref2, dut2;
   logic        busy2, done2, ffv2, pass2;
   logic [10:0] cnt2;
   logic [9:0]  ffvec2;
   logic [15:0] sig2;
   int          ph2 = 0;
   int          hold_err = 0;
   logic [9:0]  prev_vec2 = '0;
   logic        prev_busy2 = 1'b0;

   // Outputs are corrupted except in the third cycle of each vector
   assign ref2 = ref_fn(vec2);
   assign dut2 = (busy2 && ph2 != 2) ? (ref2 ^ 5'h1F) : ref2;

   case_eq_sequencer #(.SETTLE_CYC(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .vec_o(vec2),
      .ref_y_i(ref2), .dut_y_i(dut2), .golden_sig_i(16'h0000), .sig_chk_en_i(1'b0),
      .busy(busy2), .done(done2), .mismatch_cnt(cnt2), .first_fail_vec(ffvec2),
      .first_fail_valid(ffv2), .signature(sig2), .pass(pass2)
   );

   // Track the cycle index within each settle-2 vector and check each is held three cycles
   always @(negedge clk) begin
      if (busy2 && prev_busy2 && vec2 == prev_vec2) begin
         ph2 = ph2 + 1;
      end else begin
         if (busy2 && prev_busy2 && ph2 != 2) hold_err++;
         ph2 = 0;
      end
      prev_vec2  = vec2;
      prev_busy2 = busy2;
   end

   task automatic sweep0(output int bc);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      bc = 0;
      for (int n = 0; n < 4000 && !done0; n++) begin
         if (busy0) bc++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [15:0] exp_sig;
      int          bc;
      int          seq_err;
      int          n;

      exp_sig = 16'h0000;
      for (int v = 0; v < 1024; v++) exp_sig = misr_step(exp_sig, ref_fn(10'(v)));

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_vec", vec0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_ffv", ffv0, 0);
      chk("rst_ffvec", ffvec0, 0);
      chk("rst_sig", sig0, 16'h0000);
      chk("rst_pass", pass0, 0);
      rst = 1'b0;
      @(negedge clk);

      // Clean sweep
      sweep0(bc);
      chk("clean_busy_cycles", bc, 1024);
      chk("clean_done", done0, 1);
      chk("clean_cnt", cnt0, 0);
      chk("clean_ffv", ffv0, 0);
      chk("clean_pass", pass0, 1);
      chk("clean_vec_last", vec0, 10'h3FF);
      chk("clean_sig", sig0, exp_sig);
      en0 = 1'b1; golden0 = exp_sig;
      @(negedge clk);
      chk("sigchk_pass", pass0, 1);
      golden0 = exp_sig ^ 16'h0001;
      @(negedge clk);
      chk("sigchk_bad_pass", pass0, 0);
      chk("done_held", done0, 1);
      en0 = 1'b0; golden0 = 16'h0000;

      // Single injected fault
      inj = 1'b1;
      sweep0(bc);
      chk("fault_cnt", cnt0, 1);
      chk("fault_ffvec", ffvec0, 10'h2A5);
      chk("fault_ffv", ffv0, 1);
      chk("fault_pass", pass0, 0);
      inj = 1'b0;

      // Abort with simultaneous start at vec 100
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (n = 0; n < 300 && vec0 != 10'd100; n++) @(negedge clk);
      chk("abort_reach", vec0, 100);
      abort0 = 1'b1; start0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0; start0 = 1'b0;
      chk("abort_vec", vec0, 0);
      chk("abort_busy", busy0, 0);
      chk("abort_done", done0, 0);
      chk("abort_pass", pass0, 0);
      chk("abort_cnt_cleared", cnt0, 0);
      @(negedge clk);
      chk("abort_stays_idle", busy0, 0);

      // Fresh sweep after abort
      inj = 1'b1;
      sweep0(bc);
      chk("resweep_busy_cycles", bc, 1024);
      chk("resweep_cnt", cnt0, 1);
      chk("resweep_ffvec", ffvec0, 10'h2A5);
      inj = 1'b0;

      // Zero reference outputs
      zero_mode = 1'b1;
      sweep0(bc);
      chk("zero_sig", sig0, 16'h0000);
      en0 = 1'b1; golden0 = 16'h0000;
      @(negedge clk);
      chk("zero_pass", pass0, 1);
      golden0 = 16'h0001;
      @(negedge clk);
      chk("zero_bad_pass", pass0, 0);
      en0 = 1'b0; golden0 = 16'h0000; zero_mode = 1'b0;

      // Start while busy is ignored, then reset mid-sweep at vec 500
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      seq_err = 0;
      for (int k = 0; k < 500; k++) begin
         if (vec0 !== 10'(k)) seq_err++;
         start0 = (k == 300);
         @(negedge clk);
      end
      start0 = 1'b0;
      chk("seq_unbroken", seq_err, 0);
      chk("midrst_vec_pre", vec0, 500);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_vec", vec0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_cnt", cnt0, 0);
      chk("midrst_sig", sig0, 16'h0000);
      chk("midrst_done", done0, 0);
      rst = 1'b0;
      @(negedge clk);

      // Settle-2 sweep
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      bc = 0;
      for (n = 0; n < 8000 && !done2; n++) begin
         if (busy2) bc++;
         @(negedge clk);
      end
      chk("s2_busy_cycles", bc, 3072);
      chk("s2_done", done2, 1);
      chk("s2_hold", hold_err, 0);
      chk("s2_cnt", cnt2, 0);
      chk("s2_pass", pass2, 1);
      chk("s2_sig", sig2, exp_sig);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/case_eq_sequencer.md
Name: case_eq_sequencer

Overview:
Exhaustive-vector sequencer for equivalence checking of a synthesized combinational case block against its original netlist. Default case block: 10 inputs a..j, 5 outputs y1..y5. The block drives every input combination in order, waits a programmable settle time, and compares the reference and optimized outputs each vector. It reports mismatch count, first failing vector and a MISR signature of the reference outputs. It sits in the per-case check harness, one instance per case.

Parameters:
N_IN, 10, input vector width; the sweep covers 0 .. 2^N_IN-1
N_OUT, 5, output width of each compared netlist
SETTLE_CYC, 0, extra wait cycles per vector before sampling (0..15)
SIG_W, 16, MISR width; must be >= N_OUT
MISR_POLY, 16'h1021, MISR feedback polynomial
MISR_SEED, 16'h0000, MISR value loaded on start

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  one-cycle pulse; starts a sweep; honoured only in IDLE or DONE
abort  input  1  ends a running sweep; returns to IDLE
vec_o  output  N_IN  input vector driven to both netlists; {a..j} with a = MSB
ref_y_i  input  N_OUT  outputs of the original netlist
dut_y_i  input  N_OUT  outputs of the optimized netlist
golden_sig_i  input  SIG_W  expected signature
sig_chk_en_i  input  1  include the signature compare in pass
busy  output  1  high in WAIT
done  output  1  high in DONE
mismatch_cnt  output  N_IN+1  number of failing vectors; no saturation needed
first_fail_vec  output  N_IN  first vector with ref_y_i != dut_y_i
first_fail_valid  output  1  first_fail_vec is valid
signature  output  SIG_W  MISR of ref_y_i over the sweep
pass  output  1  done && mismatch_cnt==0 && (!sig_chk_en_i || signature==golden_sig_i)

Behaviour:
- Reset (sync, rst=1): state=IDLE; vec_o=0; busy=0; done=0; mismatch_cnt=0; first_fail_vec=0; first_fail_valid=0; signature=MISR_SEED; pass=0; wait counter=0.
- States: IDLE, WAIT, DONE.
- IDLE/DONE + start=1, next cycle:
  - enter WAIT;
  - vec_o=0, wcnt=SETTLE_CYC;
  - clear mismatch_cnt, first_fail_vec and first_fail_valid; signature=MISR_SEED;
  - done=0.
- WAIT with wcnt!=0: wcnt decrements; vec_o holds.
- WAIT with wcnt==0 is the sample cycle:
  - ref_y_i and dut_y_i are sampled combinationally this cycle; results are registered.
  - If ref_y_i != dut_y_i: mismatch_cnt+1. If first_fail_valid=0, load first_fail_vec=vec_o and set first_fail_valid=1.
  - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? MISR_POLY : 0) ^ zero-extended ref_y_i.
  - If vec_o == 2^N_IN-1: go to DONE; vec_o holds its last value. Otherwise vec_o+1 and wcnt=SETTLE_CYC.
- Timing: each vector occupies SETTLE_CYC+1 cycles. busy lasts exactly 2^N_IN*(SETTLE_CYC+1) cycles. done rises the cycle after the last sample.
- vec_o counting: never wraps within a sweep. The terminal compare is against the all-ones vector.
- start while in WAIT: ignored.
- abort:
  - WAIT + abort=1: next cycle IDLE, vec_o=0, busy=0, done=0. Result registers keep their partial values; pass=0.
  - abort in IDLE/DONE: no effect.
  - start and abort in the same cycle: abort wins in WAIT; start wins in IDLE/DONE.
- DONE: holds all results and done=1 until start, abort-free rst, or rst. pass is registered on DONE entry and recomputed each cycle in DONE, so it tracks sig_chk_en_i and golden_sig_i changes.
- rst mid-sweep: immediate return to the reset values on the next edge.

Decomposition:
- Package case_eq_pkg: state enum (IDLE, WAIT, DONE), default N_IN/N_OUT/SIG_W, MISR_POLY and MISR_SEED constants.
- Sub-module case_eq_misr: SIG_W-bit MISR with load (seed) and enable (sample) inputs. The FSM, counters and compare logic stay in the top.

Test Plan:
- dut_y_i tied to a golden model of ref_y_i, SETTLE_CYC=0, start pulse -> busy high for exactly 1024 cycles; done=1; mismatch_cnt=0; first_fail_valid=0; pass=1 with sig_chk_en_i=0.
- dut_y_i = ref_y_i ^ 5'b00001 only at vec 10'h2A5 -> mismatch_cnt=1; first_fail_vec=10'h2A5; first_fail_valid=1; pass=0.
- SETTLE_CYC=2 -> each vec_o value held 3 cycles; busy lasts 3072 cycles; sample occurs in the 3rd cycle of each vector.
- ref_y_i forced to 0, MISR_SEED=0 -> signature=0. golden_sig_i=0 with sig_chk_en_i=1 gives pass=1; golden_sig_i=1 gives pass=0.
- abort pulsed when vec_o=100 (plus a simultaneous start) -> next cycle IDLE, vec_o=0, busy=0, done=0. A later start gives a clean full sweep with counters cleared.
- rst asserted mid-sweep at vec 500 -> all outputs at reset values on the next edge. start while busy -> ignored, vec_o sequence unbroken.
